// File: rtl/mips_pkg.sv
// Shared MIPS multicycle control definitions: opcodes, state encodings and
// datapath mux/ALU select encodings.
package mips_pkg;

    // Primary opcode values (instr_word[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Controller states; 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EX     = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BR       = 4'd9,
        ST_JMP      = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_counter.sv
// Wrapping event counter with enable and asynchronous active-low clear.
module mc_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count enabled events; natural overflow gives the wrap to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multicycle MIPS control unit with memory-ready stalling and
// retired / illegal instruction counters.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPW      = 6,
    parameter int CNT_W    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_word,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [3:0]     r_state;
    logic [3:0]     w_state_next;
    logic           r_is_sw;
    logic [OPW-1:0] w_opcode;
    logic           w_mem_done;
    logic           w_is_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_j;
    logic           w_legal;
    logic           w_retire;
    logic           w_unused;

    // zero is consumed by the datapath via pc_write_cond; low IR bits are datapath fields
    assign w_unused = ^{zero, instr_word[31-OPW:0]};

    assign w_opcode   = instr_word[31:32-OPW];
    assign w_mem_done = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    assign w_is_rtype = (w_opcode == OPW'(OP_RTYPE));
    assign w_is_lw    = (w_opcode == OPW'(OP_LW));
    assign w_is_sw    = (w_opcode == OPW'(OP_SW));
    assign w_is_beq   = (w_opcode == OPW'(OP_BEQ));
    assign w_is_addi  = (w_opcode == OPW'(OP_ADDI));
    assign w_is_j     = (w_opcode == OPW'(OP_J));
    assign w_legal    = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_addi | w_is_j;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Remember lw vs sw at DECODE so later IR changes cannot redirect MEM_ADDR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_sw <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_is_sw <= w_is_sw;
        end
    end

    // Next-state logic; unused encodings fall through to FETCH
    always_comb begin
        w_state_next = ST_FETCH;
        case (r_state)
            ST_RST:      w_state_next = ST_FETCH;
            ST_FETCH:    w_state_next = w_mem_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_is_rtype)                w_state_next = ST_R_EX;
                else if (w_is_lw || w_is_sw)   w_state_next = ST_MEM_ADDR;
                else if (w_is_beq)             w_state_next = ST_BR;
                else if (w_is_addi)            w_state_next = ST_ADDI_EX;
                else if (w_is_j)               w_state_next = ST_JMP;
                else                           w_state_next = ST_FETCH;
            end
            ST_MEM_ADDR: w_state_next = r_is_sw ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   w_state_next = w_mem_done ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   w_state_next = ST_FETCH;
            ST_MEM_WR:   w_state_next = w_mem_done ? ST_FETCH : ST_MEM_WR;
            ST_R_EX:     w_state_next = ST_R_WB;
            ST_R_WB:     w_state_next = ST_FETCH;
            ST_BR:       w_state_next = ST_FETCH;
            ST_JMP:      w_state_next = ST_FETCH;
            ST_ADDI_EX:  w_state_next = ST_ADDI_WB;
            ST_ADDI_WB:  w_state_next = ST_FETCH;
            default:     w_state_next = ST_FETCH;
        endcase
    end

    // Output decode: everything defaults to 0, each state raises only its own controls
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = w_mem_done;
                pc_write  = w_mem_done;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                illegal   = ~w_legal;
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    // An instruction retires on its final transition back to FETCH
    assign w_retire = (r_state == ST_MEM_WB) | (r_state == ST_R_WB) |
                      (r_state == ST_BR)     | (r_state == ST_JMP)  |
                      (r_state == ST_ADDI_WB)|
                      ((r_state == ST_MEM_WR) & w_mem_done);

    mc_counter #(.W(CNT_W)) u_retired_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_retire),
        .o_count (retired)
    );

    mc_counter #(.W(CNT_W)) u_illegal_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (illegal),
        .o_count (illegal_cnt)
    );

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: a stalling instance (MEM_WAIT=1) and a no-wait, 2-bit
// counter instance (MEM_WAIT=0, CNT_W=2) checked against hand-computed values.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n, rst_b_n;
    logic [31:0] instr, instr_b;
    logic        zero, mem_ready;

    // Instance A outputs
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [15:0] retired, illegal_cnt;

    // Instance B outputs
    logic       b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_mem_to_reg;
    logic       b_ir_write, b_reg_write, b_reg_dst, b_alu_src_a, b_illegal;
    logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
    logic [3:0] b_state;
    logic [1:0] b_retired, b_illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control #(.OPW(6), .CNT_W(16), .MEM_WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_word(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal),
        .retired(retired), .illegal_cnt(illegal_cnt)
    );

    // mem_ready tied low: with MEM_WAIT=0 it must be ignored
    multicycle_control #(.OPW(6), .CNT_W(2), .MEM_WAIT(0)) dut_nw (
        .clk(clk), .rst_n(rst_b_n), .instr_word(instr_b), .zero(1'b0), .mem_ready(1'b0),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .i_or_d(b_i_or_d),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg),
        .ir_write(b_ir_write), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .pc_source(b_pc_source), .state(b_state), .illegal(b_illegal),
        .retired(b_retired), .illegal_cnt(b_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lw_seq[7] = '{0, 1, 2, 3, 4, 5, 1};
    int j_ret[5]  = '{1, 2, 3, 0, 1};
    int beq_z[2]  = '{1, 0};

    initial begin
        rst_n = 1'b0; rst_b_n = 1'b0;
        instr = 32'h0; instr_b = 32'h0;
        zero = 1'b0; mem_ready = 1'b0;
        tick(); tick();

        // ---- Instance B: lw with MEM_WAIT=0 ----
        check_val("b_reset_state", int'(b_state), 0);
        check_val("b_reset_retired", int'(b_retired), 0);
        instr_b = 32'h8C080004;
        rst_b_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            check_val("b_lw_state", int'(b_state), lw_seq[i]);
            check_val("b_lw_reg_write", int'(b_reg_write), (lw_seq[i] == 5) ? 1 : 0);
            check_val("b_lw_mem_to_reg", int'(b_mem_to_reg), (lw_seq[i] == 5) ? 1 : 0);
        end
        check_val("b_lw_retired", int'(b_retired), 1);
        $display("tx: lw (no-wait) done, retired=%0d", b_retired);

        // ---- Instance B: five jumps, 2-bit retire counter wraps ----
        rst_b_n = 1'b0;
        #1;
        rst_b_n = 1'b1;
        instr_b = 32'h08000000;
        check_val("b_j_reset_state", int'(b_state), 0);
        tick();
        check_val("b_j_fetch", int'(b_state), 1);
        check_val("b_j_ir_write", int'(b_ir_write), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("b_j_decode", int'(b_state), 2);
            tick();
            check_val("b_j_state", int'(b_state), 10);
            check_val("b_j_pc_write", int'(b_pc_write), 1);
            check_val("b_j_pc_source", int'(b_pc_source), 2);
            tick();
            check_val("b_j_back_fetch", int'(b_state), 1);
            check_val("b_j_retired", int'(b_retired), j_ret[k]);
            $display("tx: j #%0d done, retired=%0d", k, b_retired);
        end

        // ---- Instance A: R-type with 3-cycle fetch stall ----
        check_val("a_reset_state", int'(state), 0);
        check_val("a_reset_mem_read", int'(mem_read), 0);
        instr = 32'h01095020;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        check_val("a_rst_cycle_state", int'(state), 0);
        check_val("a_rst_cycle_ir_write", int'(ir_write), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("a_stall_state", int'(state), 1);
            check_val("a_stall_ir_write", int'(ir_write), 0);
            check_val("a_stall_pc_write", int'(pc_write), 0);
            check_val("a_stall_mem_read", int'(mem_read), 1);
            check_val("a_stall_alu_src_b", int'(alu_src_b), 1);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check_val("a_fetch4_state", int'(state), 1);
        check_val("a_fetch4_ir_write", int'(ir_write), 1);
        check_val("a_fetch4_pc_write", int'(pc_write), 1);
        tick();
        check_val("a_r_decode", int'(state), 2);
        check_val("a_r_dec_alu_src_b", int'(alu_src_b), 3);
        check_val("a_r_dec_ir_write", int'(ir_write), 0);
        tick();
        check_val("a_r_ex", int'(state), 7);
        check_val("a_r_ex_alu_op", int'(alu_op), 2);
        check_val("a_r_ex_src_a", int'(alu_src_a), 1);
        tick();
        check_val("a_r_wb", int'(state), 8);
        check_val("a_r_wb_reg_write", int'(reg_write), 1);
        check_val("a_r_wb_reg_dst", int'(reg_dst), 1);
        tick();
        check_val("a_r_fetch", int'(state), 1);
        check_val("a_r_retired", int'(retired), 1);
        $display("tx: R-type (stalled fetch) done, retired=%0d", retired);

        // ---- Instance A: beq with zero=1 then zero=0 ----
        for (int b = 0; b < 2; b++) begin
            zero = beq_z[b][0];
            instr = 32'h11090003;
            tick();
            check_val("a_beq_decode", int'(state), 2);
            tick();
            check_val("a_beq_state", int'(state), 9);
            check_val("a_beq_pc_write_cond", int'(pc_write_cond), 1);
            check_val("a_beq_pc_source", int'(pc_source), 1);
            check_val("a_beq_alu_op", int'(alu_op), 1);
            check_val("a_beq_pc_write", int'(pc_write), 0);
            tick();
            check_val("a_beq_fetch", int'(state), 1);
            check_val("a_beq_retired", int'(retired), 2 + b);
            $display("tx: beq zero=%0d done, retired=%0d", zero, retired);
        end

        // ---- Instance A: illegal opcode 0x3F ----
        instr = 32'hFC000000;
        tick();
        check_val("a_ill_state", int'(state), 2);
        check_val("a_ill_pulse", int'(illegal), 1);
        check_val("a_ill_reg_write", int'(reg_write), 0);
        check_val("a_ill_mem_write", int'(mem_write), 0);
        tick();
        check_val("a_ill_fetch", int'(state), 1);
        check_val("a_ill_pulse_end", int'(illegal), 0);
        check_val("a_ill_cnt", int'(illegal_cnt), 1);
        check_val("a_ill_retired", int'(retired), 3);
        $display("tx: illegal 0x3F done, illegal_cnt=%0d", illegal_cnt);

        // ---- Instance A: sw stalled in MEM_WR, reset mid-stall ----
        instr = 32'hAC080004;
        tick();
        check_val("a_sw_decode", int'(state), 2);
        tick();
        check_val("a_sw_addr", int'(state), 3);
        check_val("a_sw_addr_src_b", int'(alu_src_b), 2);
        mem_ready = 1'b0;
        tick();
        check_val("a_sw_wr", int'(state), 6);
        check_val("a_sw_mem_write", int'(mem_write), 1);
        check_val("a_sw_i_or_d", int'(i_or_d), 1);
        instr = 32'h00000000;
        tick();
        check_val("a_sw_hold", int'(state), 6);
        check_val("a_sw_hold_mem_write", int'(mem_write), 1);
        check_val("a_sw_hold_retired", int'(retired), 3);
        rst_n = 1'b0;
        #1;
        check_val("a_arst_state", int'(state), 0);
        check_val("a_arst_mem_write", int'(mem_write), 0);
        check_val("a_arst_i_or_d", int'(i_or_d), 0);
        check_val("a_arst_retired", int'(retired), 0);
        check_val("a_arst_illegal_cnt", int'(illegal_cnt), 0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        check_val("a_restart_rst", int'(state), 0);
        tick();
        check_val("a_restart_fetch", int'(state), 1);
        $display("tx: sw reset mid-stall done, state=%0d", state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
